// File: rtl/bypass_pkg.sv
// Shared types for the operand-forwarding / load-use hazard unit.
package bypass_pkg;

    // Width of the scoreboard's destination field. Register addresses narrower
    // than this are zero-extended on entry. AW must not exceed this value.
    localparam int unsigned REG_IDX_W = 8;

    typedef logic [REG_IDX_W-1:0] reg_idx_t;

    // Where an EX operand was taken from.
    typedef enum logic [1:0] {
        FWD_RF  = 2'd0,
        FWD_MEM = 2'd1,
        FWD_WB  = 2'd2,
        FWD_RET = 2'd3
    } fwd_src_e;

    // Per-operand select driven by decode. Code 3 also selects the immediate.
    typedef enum logic [1:0] {
        SEL_REG = 2'd0,
        SEL_PC  = 2'd1,
        SEL_IMM = 2'd2
    } src_sel_e;

    // One in-flight instruction as tracked by the scoreboard.
    typedef struct packed {
        logic     valid;
        reg_idx_t rd;
        logic     we;
        logic     is_load;
    } sb_entry_t;

    localparam sb_entry_t SB_BUBBLE = '{valid: 1'b0, rd: '0, we: 1'b0, is_load: 1'b0};

endpackage

// File: rtl/bypass_src_mux.sv
// One EX operand: select pc / imm / register, and for register operands pick
// the youngest in-flight producer. Hit inputs already exclude x0.
module bypass_src_mux
    import bypass_pkg::*;
#(
    parameter int unsigned XLEN = 32
) (
    input  logic [1:0]      src_sel_i,
    input  logic            hit_mem_i,
    input  logic            hit_wb_i,
    input  logic            hit_ret_i,
    input  logic [XLEN-1:0] rs_data_i,
    input  logic [XLEN-1:0] pc_i,
    input  logic [XLEN-1:0] imm_i,
    input  logic [XLEN-1:0] mem_data_i,
    input  logic [XLEN-1:0] wb_data_i,
    input  logic [XLEN-1:0] ret_data_i,
    output logic [XLEN-1:0] operand_o,
    output logic [1:0]      fwd_src_o
);

    // Priority select: pc/imm bypass forwarding entirely; otherwise MEM > WB > RET > regfile.
    always_comb begin
        // NOTE: every output gets a default first so no path can infer a latch.
        operand_o = rs_data_i;
        fwd_src_o = FWD_RF;
        if (src_sel_i == SEL_PC) begin
            operand_o = pc_i;
        end else if (src_sel_i[1]) begin
            // Codes 2 and 3 both mean immediate.
            operand_o = imm_i;
        end else if (hit_mem_i) begin
            operand_o = mem_data_i;
            fwd_src_o = FWD_MEM;
        end else if (hit_wb_i) begin
            operand_o = wb_data_i;
            fwd_src_o = FWD_WB;
        end else if (hit_ret_i) begin
            operand_o = ret_data_i;
            fwd_src_o = FWD_RET;
        end
    end

endmodule

// File: rtl/bypass_hazard_unit.sv
// Operand forwarding and load-use stall generation between ID and EX.
// A four-entry scoreboard (EX, MEM, WB, RET) shadows the pipeline; EX operands
// are resolved combinationally from it and decode is stalled while a load's
// data is not yet forwardable to the instruction waiting in ID.
module bypass_hazard_unit
    import bypass_pkg::*;
#(
    parameter int unsigned XLEN           = 32,
    parameter int unsigned AW             = 5,
    parameter int unsigned NSRC           = 2,
    // First stage whose load data may be forwarded: 2 = WB, 3 = RET.
    parameter int unsigned LOAD_FWD_STAGE = 2
) (
    input  logic                 clock,
    input  logic                 reset_n,
    input  logic                 id_valid,
    input  logic [NSRC*AW-1:0]   id_rs_addr,
    input  logic [NSRC-1:0]      id_rs_used,
    input  logic [AW-1:0]        id_rd,
    input  logic                 id_we,
    input  logic                 id_is_load,
    input  logic                 flush,
    input  logic [NSRC*XLEN-1:0] ex_rs_data,
    input  logic [NSRC*2-1:0]    ex_src_sel,
    input  logic [XLEN-1:0]      pc,
    input  logic [XLEN-1:0]      imm,
    input  logic [XLEN-1:0]      mem_data,
    input  logic [XLEN-1:0]      wb_data,
    output logic                 stall,
    output logic [NSRC*XLEN-1:0] ex_operand,
    output logic [NSRC*2-1:0]    ex_fwd_src
);

    // A load in stage index j (EX = 0, MEM = 1) blocks its consumer while
    // j + 1 is still short of the first forwardable stage.
    localparam logic EX_LOAD_BLOCKS  = (LOAD_FWD_STAGE > 1);
    localparam logic MEM_LOAD_BLOCKS = (LOAD_FWD_STAGE > 2);

    sb_entry_t ex_q, ex_d;
    sb_entry_t mem_q, wb_q, ret_q;
    logic [NSRC*AW-1:0] ex_rs_addr_q, ex_rs_addr_d;
    logic [XLEN-1:0]    ret_data_q;

    logic [NSRC-1:0] hit_mem, hit_wb, hit_ret;
    logic            load_hazard;
    logic            stall_int;

    // Only the EX and MEM load flags feed the hazard check; later stages carry
    // the flag purely to keep every entry the same shape.
    logic unused_is_load;
    assign unused_is_load = wb_q.is_load ^ ret_q.is_load;

    // Producer matches for each EX source; x0 never matches.
    always_comb begin
        hit_mem = '0;
        hit_wb  = '0;
        hit_ret = '0;
        for (int s = 0; s < NSRC; s++) begin
            if (ex_rs_addr_q[s*AW +: AW] != '0) begin
                hit_mem[s] = mem_q.valid && mem_q.we &&
                             (mem_q.rd == reg_idx_t'(ex_rs_addr_q[s*AW +: AW]));
                hit_wb[s]  = wb_q.valid && wb_q.we &&
                             (wb_q.rd == reg_idx_t'(ex_rs_addr_q[s*AW +: AW]));
                hit_ret[s] = ret_q.valid && ret_q.we &&
                             (ret_q.rd == reg_idx_t'(ex_rs_addr_q[s*AW +: AW]));
            end
        end
    end

    // Load-use detection: a used ID source waits on a load whose data is not yet forwardable.
    always_comb begin
        load_hazard = 1'b0;
        for (int s = 0; s < NSRC; s++) begin
            if (id_rs_used[s] && (id_rs_addr[s*AW +: AW] != '0)) begin
                if (EX_LOAD_BLOCKS && ex_q.valid && ex_q.we && ex_q.is_load &&
                    (ex_q.rd == reg_idx_t'(id_rs_addr[s*AW +: AW]))) begin
                    load_hazard = 1'b1;
                end
                if (MEM_LOAD_BLOCKS && mem_q.valid && mem_q.we && mem_q.is_load &&
                    (mem_q.rd == reg_idx_t'(id_rs_addr[s*AW +: AW]))) begin
                    load_hazard = 1'b1;
                end
            end
        end
    end

    // A taken branch kills ID, so flush overrides any stall request.
    assign stall_int = !flush && id_valid && load_hazard;
    assign stall     = stall_int;

    // Next EX entry: the ID instruction if it advances, otherwise a bubble.
    always_comb begin
        ex_d         = SB_BUBBLE;
        ex_rs_addr_d = '0;
        if (id_valid && !stall_int && !flush) begin
            ex_d.valid   = 1'b1;
            ex_d.rd      = reg_idx_t'(id_rd);
            ex_d.we      = id_we;
            ex_d.is_load = id_is_load;
            ex_rs_addr_d = id_rs_addr;
        end
    end

    // Scoreboard shift; it never holds, since stalls only insert bubbles into EX.
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            ex_q         <= SB_BUBBLE;
            mem_q        <= SB_BUBBLE;
            wb_q         <= SB_BUBBLE;
            ret_q        <= SB_BUBBLE;
            ex_rs_addr_q <= '0;
            ret_data_q   <= '0;
        end else begin
            // NOTE: non-blocking updates let every stage read the pre-edge value of its predecessor.
            ex_q         <= ex_d;
            mem_q        <= ex_q;
            wb_q         <= mem_q;
            ret_q        <= wb_q;
            ex_rs_addr_q <= ex_rs_addr_d;
            ret_data_q   <= wb_data;
        end
    end

    // One priority mux per EX operand.
    for (genvar s = 0; s < NSRC; s++) begin : g_src
        bypass_src_mux #(
            .XLEN(XLEN)
        ) u_src_mux (
            .src_sel_i (ex_src_sel[s*2 +: 2]),
            .hit_mem_i (hit_mem[s]),
            .hit_wb_i  (hit_wb[s]),
            .hit_ret_i (hit_ret[s]),
            .rs_data_i (ex_rs_data[s*XLEN +: XLEN]),
            .pc_i      (pc),
            .imm_i     (imm),
            .mem_data_i(mem_data),
            .wb_data_i (wb_data),
            .ret_data_i(ret_data_q),
            .operand_o (ex_operand[s*XLEN +: XLEN]),
            .fwd_src_o (ex_fwd_src[s*2 +: 2])
        );
    end

endmodule

// File: tb/tb_bypass_hazard_unit.sv
// Bench for bypass_hazard_unit: two instances (load data forwardable from WB and
// from RET) share one stimulus stream. A reference model tracks the instructions
// by age; expectations are queued per cycle and checked by a separate monitor.
module tb_bypass_hazard_unit;

    localparam int XLEN = 32;
    localparam int AW   = 5;
    localparam int NSRC = 2;

    logic                 clock = 1'b0;
    logic                 reset_n;
    logic                 id_valid;
    logic [NSRC*AW-1:0]   id_rs_addr;
    logic [NSRC-1:0]      id_rs_used;
    logic [AW-1:0]        id_rd;
    logic                 id_we;
    logic                 id_is_load;
    logic                 flush;
    logic [NSRC*XLEN-1:0] ex_rs_data;
    logic [NSRC*2-1:0]    ex_src_sel;
    logic [XLEN-1:0]      pc;
    logic [XLEN-1:0]      imm;
    logic [XLEN-1:0]      mem_data;
    logic [XLEN-1:0]      wb_data;

    logic                 stall_a, stall_b;
    logic [NSRC*XLEN-1:0] op_a, op_b;
    logic [NSRC*2-1:0]    fs_a, fs_b;

    always #5 clock = ~clock;

    bypass_hazard_unit #(.XLEN(XLEN), .AW(AW), .NSRC(NSRC), .LOAD_FWD_STAGE(2)) dut_lf2 (
        .clock(clock), .reset_n(reset_n), .id_valid(id_valid), .id_rs_addr(id_rs_addr),
        .id_rs_used(id_rs_used), .id_rd(id_rd), .id_we(id_we), .id_is_load(id_is_load),
        .flush(flush), .ex_rs_data(ex_rs_data), .ex_src_sel(ex_src_sel), .pc(pc), .imm(imm),
        .mem_data(mem_data), .wb_data(wb_data), .stall(stall_a), .ex_operand(op_a),
        .ex_fwd_src(fs_a)
    );

    bypass_hazard_unit #(.XLEN(XLEN), .AW(AW), .NSRC(NSRC), .LOAD_FWD_STAGE(3)) dut_lf3 (
        .clock(clock), .reset_n(reset_n), .id_valid(id_valid), .id_rs_addr(id_rs_addr),
        .id_rs_used(id_rs_used), .id_rd(id_rd), .id_we(id_we), .id_is_load(id_is_load),
        .flush(flush), .ex_rs_data(ex_rs_data), .ex_src_sel(ex_src_sel), .pc(pc), .imm(imm),
        .mem_data(mem_data), .wb_data(wb_data), .stall(stall_b), .ex_operand(op_b),
        .ex_fwd_src(fs_b)
    );

    // ---------------- reference model ----------------
    typedef struct packed {
        logic                      valid;
        logic                      we;
        logic                      ld;
        logic [AW-1:0]             rd;
        logic [NSRC-1:0][AW-1:0]   rs;
    } ins_t;

    // pipe[m][age]: age 0 = instruction in EX, 1..3 = older producers.
    ins_t          pipe [2][4];
    logic [XLEN-1:0] ret_val;

    typedef struct {
        int                   m;
        logic                 stall;
        logic [NSRC*XLEN-1:0] op;
        logic [NSRC*2-1:0]    fs;
        bit                   chk_ops;
        string                tag;
    } exp_t;

    exp_t sb_q[$];
    int   n_checks = 0;
    int   n_pass   = 0;

    function automatic int lfs_of(int m);
        return (m == 0) ? 2 : 3;
    endfunction

    function automatic bit writes(int m, int age, logic [AW-1:0] r);
        return pipe[m][age].valid && pipe[m][age].we && (pipe[m][age].rd == r) && (r != 0);
    endfunction

    function automatic logic model_stall(int m);
        if (flush || !id_valid) return 1'b0;
        for (int s = 0; s < NSRC; s++) begin
            if (id_rs_used[s]) begin
                for (int age = 0; age < 2; age++) begin
                    if ((age + 1 < lfs_of(m)) && pipe[m][age].ld &&
                        writes(m, age, id_rs_addr[s*AW +: AW])) return 1'b1;
                end
            end
        end
        return 1'b0;
    endfunction

    function automatic void model_ops(int m, output logic [NSRC*XLEN-1:0] op,
                                      output logic [NSRC*2-1:0] fs, output bit chk);
        op = '0;
        fs = '0;
        for (int s = 0; s < NSRC; s++) begin
            logic [1:0] sel;
            int         src;
            sel = ex_src_sel[2*s +: 2];
            if (sel == 2'd1) begin
                op[s*XLEN +: XLEN] = pc;
            end else if (sel >= 2'd2) begin
                op[s*XLEN +: XLEN] = imm;
            end else begin
                src = 0;
                // Scan oldest to youngest so the youngest producer overrides.
                for (int age = 3; age >= 1; age--)
                    if (writes(m, age, pipe[m][0].rs[s])) src = age;
                case (src)
                    1:       op[s*XLEN +: XLEN] = mem_data;
                    2:       op[s*XLEN +: XLEN] = wb_data;
                    3:       op[s*XLEN +: XLEN] = ret_val;
                    default: op[s*XLEN +: XLEN] = ex_rs_data[s*XLEN +: XLEN];
                endcase
                fs[2*s +: 2] = 2'(src);
            end
        end
        // A bubble in EX has no defined sources unless nothing could forward anyway.
        chk = pipe[m][0].valid || !(pipe[m][1].valid || pipe[m][2].valid || pipe[m][3].valid);
    endfunction

    task automatic clear_model();
        for (int m = 0; m < 2; m++)
            for (int a = 0; a < 4; a++) pipe[m][a] = '0;
        ret_val = '0;
    endtask

    task automatic advance();
        logic st [2];
        ins_t n;
        for (int m = 0; m < 2; m++) st[m] = model_stall(m);
        n.valid = 1'b1;
        n.we    = id_we;
        n.ld    = id_is_load;
        n.rd    = id_rd;
        n.rs    = id_rs_addr;
        for (int m = 0; m < 2; m++) begin
            pipe[m][3] = pipe[m][2];
            pipe[m][2] = pipe[m][1];
            pipe[m][1] = pipe[m][0];
            pipe[m][0] = (id_valid && !st[m] && !flush) ? n : '0;
        end
        ret_val = wb_data;
    endtask

    // Queue this cycle's expectations, then move to the next cycle.
    task automatic step(string tag);
        exp_t e;
        for (int m = 0; m < 2; m++) begin
            e.m     = m;
            e.stall = model_stall(m);
            model_ops(m, e.op, e.fs, e.chk_ops);
            e.tag   = tag;
            sb_q.push_back(e);
        end
        @(posedge clock);
        if (reset_n) advance();
        #1;
    endtask

    task automatic drive(string tag, bit v, int a0, int a1, bit [1:0] used, int rd,
                         bit we, bit ld, bit fl, bit [3:0] sel = 4'b0);
        id_valid   = v;
        id_rs_addr = {AW'(a1), AW'(a0)};
        id_rs_used = used;
        id_rd      = AW'(rd);
        id_we      = we;
        id_is_load = ld;
        flush      = fl;
        ex_src_sel = sel;
        ex_rs_data = {$urandom, $urandom};
        pc         = $urandom;
        imm        = $urandom;
        mem_data   = $urandom;
        wb_data    = $urandom;
        step(tag);
    endtask

    // ---------------- checking ----------------
    task automatic check(string name, int m, logic [63:0] act, logic [63:0] exp);
        n_checks++;
        if (act === exp) n_pass++;
        else $display("FAIL %s lfs=%0d t=%0t got=%h exp=%h", name, lfs_of(m), $time, act, exp);
    endtask

    // Monitor: outputs are combinational, so every queued cycle is compared mid-cycle.
    always @(negedge clock) begin
        while (sb_q.size() > 0) begin
            exp_t e;
            e = sb_q.pop_front();
            check({e.tag, "_stall"}, e.m, 64'(e.m == 0 ? stall_a : stall_b), 64'(e.stall));
            if (e.chk_ops) begin
                check({e.tag, "_operand"}, e.m, 64'(e.m == 0 ? op_a : op_b), 64'(e.op));
                check({e.tag, "_fwd_src"}, e.m, 64'(e.m == 0 ? fs_a : fs_b), 64'(e.fs));
            end
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog t=%0t", $time);
        $fatal(1, "timeout");
    end

    // ---------------- stimulus ----------------
    initial begin
        reset_n = 1'b0;
        clear_model();
        @(posedge clock);
        #1;
        drive("reset", 1, 0, 0, 2'b00, 0, 0, 0, 0);
        drive("reset_sel", 0, 0, 0, 2'b00, 0, 0, 0, 0, 4'b1001);
        reset_n = 1'b1;

        // Back-to-back ALU dependency on x5.
        drive("alu_prod", 1, 0, 0, 2'b00, 5, 1, 0, 0);
        drive("alu_cons", 1, 5, 3, 2'b11, 8, 1, 0, 0);
        drive("alu_fwd_mem", 0, 0, 0, 2'b00, 0, 0, 0, 0);

        // Distances 2 and 3 on x6, then a younger x6 producer.
        drive("d2_prod", 1, 0, 0, 2'b00, 6, 1, 0, 0);
        drive("d2_gap", 1, 1, 2, 2'b11, 1, 1, 0, 0);
        drive("d2_cons", 1, 2, 6, 2'b11, 2, 1, 0, 0);
        drive("d2_fwd_wb", 1, 0, 0, 2'b00, 6, 1, 0, 0);
        drive("d3_gap1", 1, 0, 0, 2'b00, 6, 1, 0, 0);
        drive("young_cons", 1, 6, 0, 2'b01, 3, 1, 0, 0);
        drive("young_fwd", 0, 0, 0, 2'b00, 0, 0, 0, 0);
        drive("d3_prod", 1, 0, 0, 2'b00, 6, 1, 0, 0);
        drive("d3_gap_a", 0, 0, 0, 2'b00, 0, 0, 0, 0);
        drive("d3_gap_b", 0, 0, 0, 2'b00, 0, 0, 0, 0);
        drive("d3_cons", 1, 6, 6, 2'b11, 4, 1, 0, 0);
        drive("d3_fwd_ret", 0, 0, 0, 2'b00, 0, 0, 0, 0);

        // Load-use on x7; the consumer is held in ID across the stall.
        drive("lu_load", 1, 0, 0, 2'b00, 7, 1, 1, 0);
        drive("lu_stall1", 1, 7, 1, 2'b11, 8, 1, 0, 0);
        drive("lu_stall2", 1, 7, 1, 2'b11, 8, 1, 0, 0);
        drive("lu_issue", 1, 7, 1, 2'b11, 8, 1, 0, 0);
        drive("lu_fwd", 0, 0, 0, 2'b00, 0, 0, 0, 0);
        drive("lu_drain", 0, 0, 0, 2'b00, 0, 0, 0, 0);

        // x0 destination and unused source: no forwarding, no stall.
        drive("x0_load", 1, 0, 0, 2'b00, 0, 1, 1, 0);
        drive("x0_cons", 1, 0, 0, 2'b11, 9, 1, 0, 0);
        drive("nouse_load", 1, 0, 0, 2'b00, 7, 1, 1, 0);
        drive("nouse_cons", 1, 7, 2, 2'b10, 9, 1, 0, 0);
        drive("nouse_next", 0, 0, 0, 2'b00, 0, 0, 0, 0);

        // Flush during a load-use stall.
        drive("fl_load", 1, 0, 0, 2'b00, 7, 1, 1, 0);
        drive("fl_flush", 1, 7, 0, 2'b01, 8, 1, 0, 1);
        drive("fl_after", 1, 7, 0, 2'b01, 8, 1, 0, 0);
        drive("fl_drain", 0, 0, 0, 2'b00, 0, 0, 0, 0);
        drive("fl_drain2", 0, 0, 0, 2'b00, 0, 0, 0, 0);

        // pc / imm selection with a matching MEM producer.
        drive("sel_prod", 1, 0, 0, 2'b00, 9, 1, 0, 0);
        drive("sel_cons", 1, 9, 9, 2'b11, 10, 1, 0, 0);
        drive("sel_pc_imm", 0, 0, 0, 2'b00, 0, 0, 0, 0, 4'b1001);
        drive("sel_imm3", 0, 0, 0, 2'b00, 0, 0, 0, 0, 4'b0111);

        // Asynchronous reset in the middle of a stall.
        drive("rs_load", 1, 0, 0, 2'b00, 7, 1, 1, 0);
        drive("rs_stall", 1, 7, 0, 2'b01, 8, 1, 0, 0);
        reset_n = 1'b0;
        clear_model();
        drive("rs_mid", 1, 7, 0, 2'b01, 8, 1, 0, 0);
        reset_n = 1'b1;
        drive("rs_after", 1, 7, 7, 2'b11, 8, 1, 0, 0);
        drive("rs_nofwd", 0, 0, 0, 2'b00, 0, 0, 0, 0);

        // Randomized traffic over a small register set to provoke collisions.
        for (int i = 0; i < 600; i++) begin
            bit [3:0] sel;
            for (int s = 0; s < NSRC; s++)
                sel[2*s +: 2] = ($urandom_range(0, 99) < 85) ? 2'd0 : 2'($urandom_range(1, 3));
            drive("rand", $urandom_range(0, 99) < 85,
                  $urandom_range(0, 3), $urandom_range(0, 3), 2'($urandom_range(0, 3)),
                  $urandom_range(0, 3), $urandom_range(0, 99) < 75,
                  $urandom_range(0, 99) < 35, $urandom_range(0, 99) < 8, sel);
        end

        @(negedge clock);
        #1;
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule

// File: doc/bypass_hazard_unit.md
# bypass_hazard_unit

Parametrised operand-forwarding and load-use hazard unit for the five-stage RISC-V pipeline, sitting between decode (ID) and execute (EX). It tracks the destination of every in-flight instruction in an internal scoreboard (EX, MEM, WB, RET), resolves each of NSRC execute operands by priority forwarding, and stalls decode for load-use hazards. Compared with the earlier single-cycle bypass, it adds:
- a post-writeback (RET) forwarding stage;
- x0 suppression;
- per-source use masks;
- a configurable load-data stage;
- flush handling.

## Interface
Parameters:
- XLEN, 32, datapath width
- AW, 5, register-address width
- NSRC, 2, number of execute source operands
- LOAD_FWD_STAGE, 2, first stage whose load data is forwardable (2 = WB, 3 = RET); other values illegal

Ports:
- clock  in  1  pipeline clock, all state on rising edge
- reset_n  in  1  asynchronous, active-low reset
- id_valid  in  1  ID holds a real instruction
- id_rs_addr  in  NSRC*AW  ID source register numbers, source s at [s*AW +: AW]
- id_rs_used  in  NSRC  source s is actually read by the ID instruction
- id_rd  in  AW  ID destination register
- id_we  in  1  ID instruction writes id_rd
- id_is_load  in  1  ID instruction is a load
- flush  in  1  branch/jump resolved taken in EX; kill ID
- ex_rs_data  in  NSRC*XLEN  register-file data registered into EX
- ex_src_sel  in  NSRC*2  per-source operand select: 0 reg, 1 pc, 2/3 imm
- pc  in  XLEN  EX program counter
- imm  in  XLEN  EX immediate (shamt already folded in by decode)
- mem_data  in  XLEN  MEM-stage result (ALU result; load data only when LOAD_FWD_STAGE = 2 and stage ≥ WB)
- wb_data  in  XLEN  WB-stage write-back value
- stall  out  1  hold PC and IF/ID; insert bubble into EX
- ex_operand  out  NSRC*XLEN  resolved EX operands
- ex_fwd_src  out  NSRC*2  per source: 0 regfile, 1 MEM, 2 WB, 3 RET (0 when pc/imm selected)

## Operation
- The scoreboard has entries EX, MEM, WB and RET. Each entry holds {valid, rd, we, is_load}. EX additionally holds the NSRC source addresses.
- Each cycle the scoreboard shifts: RET←WB, WB←MEM, MEM←EX. ret_data←wb_data, captured unconditionally.
- EX load rule: if id_valid && !stall && !flush, EX←ID fields. Otherwise EX←bubble (valid = 0, rd = 0, we = 0, is_load = 0).
- An entry "writes r" when valid && we && rd == r && r != 0.
- Forward source per EX operand s with ex_src_sel == 0 (r = EX source address):
  - MEM entry writes r → mem_data.
  - Else WB entry writes r → wb_data.
  - Else RET entry writes r → ret_data.
  - Else ex_rs_data.
  - Youngest producer wins.
- If ex_src_sel is 1, the operand is pc; if 2 or 3, it is imm. In both cases there is no forwarding and ex_fwd_src = 0.
- r == 0 always selects ex_rs_data, which the register file holds at 0.
- Load-use hazard: stall = !flush && id_valid && OR over sources s with id_rs_used[s] of (stage j ∈ {EX, MEM} writes id_rs_addr[s], is_load set, and j_index+1 < LOAD_FWD_STAGE). EX has index 0 and MEM has index 1.
  - LOAD_FWD_STAGE = 2 gives one bubble.
  - LOAD_FWD_STAGE = 3 gives two bubbles.
- flush has priority over stall. When flush is high, stall is 0 and a bubble enters EX.
- The scoreboard never holds; the pipeline has no back-pressure beyond stall.

## Timing
- Reset (reset_n low, asynchronous): all entries are bubbles, ret_data = 0, stall = 0. ex_operand follows the combinational path, which is ex_rs_data/pc/imm with ex_fwd_src = 0.
- ex_operand, ex_fwd_src and stall are combinational from current state and inputs: zero-cycle latency.
- Scoreboard update latency is one cycle.
- A producer is forwardable for 3 cycles after leaving EX (MEM, WB, RET). After that the register file already holds the value.
- A stall lasts exactly as long as the hazard persists. It deasserts automatically as the load advances.
- If reset is asserted mid-stall, stall drops immediately and all in-flight tracking is lost.
- Simultaneous matches in several stages: the youngest wins, per the priority order above.

## Structure
- Package bypass_pkg holds:
  - fwd_src codes FWD_RF/FWD_MEM/FWD_WB/FWD_RET;
  - operand-select codes SEL_REG/SEL_PC/SEL_IMM;
  - the scoreboard entry struct {valid, rd, we, is_load}.
- Sub-module bypass_src_mux: one source's priority mux plus fwd_src encode. It is instantiated NSRC times via generate.
- Scoreboard and hazard logic live in the top module.

## Test plan
- Back-to-back ALU dependency: x5 = 7 in EX, then consumer reads x5 next → ex_fwd_src = 1, operand = 7, stall = 0.
- Producer-to-consumer distances 2 and 3 (x6 = 0x1234): ex_fwd_src = 2 then 3, operand 0x1234. With a younger producer writing x6 = 9 in MEM, the operand is 9 (source 1).
- Load-use, default parameters: lw x7 followed by add using x7 → stall high exactly 1 cycle, then ex_fwd_src = 2 with loaded value. With LOAD_FWD_STAGE = 3 → stall 2 cycles, then source 3.
- Destination x0, or id_rs_used = 0 on the matching source → no forwarding and no stall.
- Flush during load-use stall → stall = 0 that cycle and an EX bubble. Next-cycle MEM entry valid = 0.
- ex_src_sel = 1/2 with a matching MEM producer → operand = pc/imm and ex_fwd_src = 0.
- Async reset_n pulse mid-stall → stall = 0 immediately. After release, no forwarding until new producers enter.
